wb_stream_fifo: RTL and testbench

- Wishbone B4 slave that occupies the FIFO slots of the SD DMA mux (slave IDs 2/3). It stands in for RAM as a streaming sink and source for the SD controller's DMA master.
- TX path: DMA writes to the data address push words into a TX FIFO, which drains on an AXI-Stream-style master port.
- RX path: an AXI-Stream-style slave port fills an RX FIFO, which DMA reads drain.
- A status word exposes both fill levels.

---
 rtl/wb_stream_pkg.sv | 26 ++
 rtl/wb_stream_fifo_sync_fifo.sv | 66 ++++++
 rtl/wb_stream_fifo.sv | 129 ++++++++++++
 tb/tb_wb_stream_fifo.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_pkg.sv
// Shared constants and address decode for the Wishbone streaming FIFO slave.
// Bus cycle-type codes and register offsets live here so RTL and bench agree.
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    typedef enum logic [1:0] {
        ACC_DATA   = 2'd0,
        ACC_STATUS = 2'd1,
        ACC_RSVD   = 2'd2
    } acc_e;

    function automatic acc_e decode_addr(input logic [1:0] off);
        case (off)
            ADDR_DATA:   return ACC_DATA;
            ADDR_STATUS: return ACC_STATUS;
            default:     return ACC_RSVD;
        endcase
    endfunction

endpackage

// File: rtl/wb_stream_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an exact registered level.
// Storage is read through a registered port so it maps onto block RAM.
module sync_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 512,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);
    localparam int PW = LW - 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] head_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = head_q;
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Head is prefetched from the next read address; a word written into that
    // very slot on this edge is forwarded so the head never goes stale.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
        head_q <= (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
    end

endmodule

// File: rtl/wb_stream_fifo.sv
// Wishbone B4 slave bridging DMA word traffic to a pair of stream FIFOs:
// DATA writes feed the TX stream, DATA reads drain the RX stream.
module wb_stream_fifo
    import wb_stream_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 512,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [LW-1:0] tx_level_o,
    output logic [LW-1:0] rx_level_o
);
    logic          tx_full, tx_empty, tx_pop;
    logic          rx_full, rx_empty, rx_push;
    logic [DW-1:0] rx_head;
    logic          ack_q, ack_d, err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          sel_ok, req, wr_go, rd_go, st_go;
    acc_e          acc;
    logic          unused_bits;

    assign unused_bits = ^{wb_adr_i[AW-1:4], wb_adr_i[1:0], wb_bte_i};

    assign acc      = decode_addr(wb_adr_i[3:2]);
    assign sel_ok   = (wb_sel_i == 4'hF);
    // A registered response blocks the next request unless the master declared
    // an incrementing burst, which lets acks run back to back.
    assign req      = wb_cyc_i & wb_stb_i & (~(ack_q | err_q) | (wb_cti_i == CTI_INCR));
    assign tx_pop   = m_tvalid & m_tready;
    assign rx_push  = s_tvalid & s_tready;
    assign m_tvalid = ~tx_empty;
    assign s_tready = wb_rst_ni & ~rx_full;

    always_comb begin
        wr_go = 1'b0;
        rd_go = 1'b0;
        st_go = 1'b0;
        err_d = 1'b0;
        if (req) begin
            case (acc)
                ACC_DATA: begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else if (wb_we_i) begin
                        wr_go = ~tx_full | tx_pop;
                    end else begin
                        rd_go = ~rx_empty;
                    end
                end
                ACC_STATUS: begin
                    if (wb_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        st_go = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
        ack_d = wr_go | rd_go | st_go;
        dat_d = dat_q;
        if (rd_go) begin
            dat_d = rx_head;
        end else if (st_go) begin
            dat_d = {16'(rx_level_o), 16'(tx_level_o)};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (wr_go),
        .pop_i   (tx_pop),
        .wdata_i (wb_dat_i),
        .rdata_o (m_tdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level_o)
    );

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (rx_push),
        .pop_i   (rd_go),
        .wdata_i (s_tdata),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level_o)
    );

endmodule

// File: tb/tb_wb_stream_fifo.sv
// Scoreboard bench for wb_stream_fifo: expected stream and bus data are queued
// when stimulus is driven and compared when the DUT delivers them.
module tb_wb_stream_fifo;
    import wb_stream_pkg::*;

    localparam int DEPTH = 512;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   adr, dat_w, dat_r, m_tdata, s_tdata;
    logic [3:0]    sel;
    logic          we, cyc, stb, ack, err;
    logic [2:0]    cti;
    logic          m_tvalid, m_tready, s_tvalid, s_tready;
    logic [LW-1:0] tx_level, rx_level;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    always #5 clk = ~clk;

    wb_stream_fifo #(.DW(32), .AW(32), .DEPTH(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_cti_i   (cti),
        .wb_bte_i   (2'b00),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_dat_o   (dat_r),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .tx_level_o (tx_level),
        .rx_level_o (rx_level)
    );

    // Single classic transfer; returns what the bus answered and how many edges it took.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic got_ack, output logic got_err,
                           output logic [31:0] rdata, output int lat);
        adr = a; we = w; dat_w = d; sel = s; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
        got_ack = 1'b0; got_err = 1'b0; rdata = '0; lat = 0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge clk); #1;
            lat++;
            if (ack || err) begin
                got_ack = ack; got_err = err; rdata = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rx_push(input logic [31:0] d);
        s_tdata = d; s_tvalid = 1'b1;
        rx_q.push_back(d);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic test_tx_drain();
        logic [31:0] exp;
        m_tready = 1'b1;
        while (tx_q.size() > 0) begin
            exp = tx_q.pop_front();
            n_total++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp)
                $display("FAIL tx_stream: got valid=%0b data=%h, expected valid=1 data=%h", m_tvalid, m_tdata, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
        n_total++;
        if (m_tvalid !== 1'b0 || tx_level !== '0)
            $display("FAIL tx_drained: got valid=%0b level=%0d, expected 0/0", m_tvalid, tx_level);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({ack, err, m_tvalid, s_tready} !== 4'b0000)
            $display("FAIL reset_flags: got ack/err/tvalid/tready=%b, expected 0000", {ack, err, m_tvalid, s_tready});
        else n_pass++;
        n_total++;
        if (dat_r !== 32'h0 || tx_level !== '0 || rx_level !== '0)
            $display("FAIL reset_state: got dat=%h tx=%0d rx=%0d, expected 0/0/0", dat_r, tx_level, rx_level);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (s_tready !== 1'b1) $display("FAIL reset_tready: got %0b, expected 1", s_tready);
        else n_pass++;
        $display("reset: done");
    endtask

    task automatic test_classic_write();
        logic a, e; logic [31:0] r; int lat;
        wb_xfer(32'h0, 1'b1, 32'hA5A5_0001, 4'hF, a, e, r, lat);
        tx_q.push_back(32'hA5A5_0001);
        $display("write DATA 0xA5A5_0001: ack=%0b err=%0b lat=%0d", a, e, lat);
        n_total++;
        if (a !== 1'b1 || e !== 1'b0 || lat != 1)
            $display("FAIL wr_ack: got ack=%0b err=%0b lat=%0d, expected 1/0/1", a, e, lat);
        else n_pass++;
        n_total++;
        if (tx_level !== LW'(1) || m_tvalid !== 1'b1)
            $display("FAIL wr_level: got level=%0d valid=%0b, expected 1/1", tx_level, m_tvalid);
        else n_pass++;
        test_tx_drain();
    endtask

    task automatic test_classic_read();
        logic a, e; logic [31:0] r, exp; int lat;
        rx_push(32'h1234_5678);
        n_total++;
        if (rx_level !== LW'(1)) $display("FAIL rd_level_before: got %0d, expected 1", rx_level);
        else n_pass++;
        wb_xfer(32'h0, 1'b0, 32'h0, 4'hF, a, e, r, lat);
        exp = rx_q.pop_front();
        $display("read DATA: ack=%0b data=%h lat=%0d", a, r, lat);
        n_total++;
        if (a !== 1'b1 || r !== exp || lat != 1)
            $display("FAIL rd_data: got ack=%0b data=%h lat=%0d, expected 1/%h/1", a, r, lat, exp);
        else n_pass++;
        n_total++;
        if (rx_level !== '0) $display("FAIL rd_level_after: got %0d, expected 0", rx_level);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int idx, stall_acks;
        m_tready = 1'b0;
        adr = 32'h0; we = 1'b1; sel = 4'hF; cti = CTI_INCR; cyc = 1'b1; stb = 1'b1;
        idx = 0; dat_w = 32'hB000_0000;
        for (int c = 0; c < DEPTH; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                tx_q.push_back(dat_w);
                idx++;
                dat_w = 32'hB000_0000 + 32'(idx);
            end
        end
        $display("INCR burst: %0d acks in %0d cycles", idx, DEPTH);
        n_total++;
        if (idx != DEPTH) $display("FAIL burst_acks: got %0d, expected %0d", idx, DEPTH);
        else n_pass++;
        stall_acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack || err) stall_acks++;
        end
        n_total++;
        if (stall_acks != 0 || tx_level !== LW'(DEPTH))
            $display("FAIL burst_stall: got acks=%0d level=%0d, expected 0/%0d", stall_acks, tx_level, DEPTH);
        else n_pass++;
        m_tready = 1'b1;
        n_total++;
        if (m_tdata !== tx_q[0]) $display("FAIL full_pop_data: got %h, expected %h", m_tdata, tx_q[0]);
        else n_pass++;
        void'(tx_q.pop_front());
        @(posedge clk); #1;
        m_tready = 1'b0;
        tx_q.push_back(dat_w);
        $display("full push+pop: ack=%0b level=%0d", ack, tx_level);
        n_total++;
        if (ack !== 1'b1 || tx_level !== LW'(DEPTH))
            $display("FAIL full_push_pop: got ack=%0b level=%0d, expected 1/%0d", ack, tx_level, DEPTH);
        else n_pass++;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        test_tx_drain();
    endtask

    task automatic test_rx_stall();
        int early;
        logic [31:0] exp;
        adr = 32'h0; we = 1'b0; sel = 4'hF; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
        early = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ack || err) early++;
        end
        n_total++;
        if (early != 0) $display("FAIL rx_empty_stall: got %0d responses, expected 0", early);
        else n_pass++;
        rx_push(32'hDEAD_BEEF);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rx_push_edge: got ack=%0b, expected 0", ack);
        else n_pass++;
        @(posedge clk); #1;
        exp = rx_q.pop_front();
        $display("stalled read: ack=%0b data=%h", ack, dat_r);
        n_total++;
        if (ack !== 1'b1 || dat_r !== exp)
            $display("FAIL rx_stall_data: got ack=%0b data=%h, expected 1/%h", ack, dat_r, exp);
        else n_pass++;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_err_status();
        logic a, e; logic [31:0] r, exp; int lat;
        logic [31:0] eadr [3] = '{32'h0, 32'h4, 32'h8};
        logic        ewe  [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  esel [3] = '{4'h3, 4'hF, 4'hF};
        for (int i = 0; i < 3; i++) begin
            wb_xfer(32'h0, 1'b1, 32'hC000_0000 + 32'(i), 4'hF, a, e, r, lat);
            tx_q.push_back(32'hC000_0000 + 32'(i));
        end
        for (int i = 0; i < 5; i++) rx_push(32'hD000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            wb_xfer(eadr[i], ewe[i], 32'hFFFF_FFFF, esel[i], a, e, r, lat);
            $display("err case %0d adr=%h we=%0b sel=%h: ack=%0b err=%0b", i, eadr[i], ewe[i], esel[i], a, e);
            n_total++;
            if (a !== 1'b0 || e !== 1'b1 || lat != 1 || err !== 1'b0)
                $display("FAIL err_case%0d: got ack=%0b err=%0b lat=%0d err_after=%0b, expected 0/1/1/0", i, a, e, lat, err);
            else n_pass++;
            n_total++;
            if (tx_level !== LW'(3) || rx_level !== LW'(5))
                $display("FAIL err_levels%0d: got tx=%0d rx=%0d, expected 3/5", i, tx_level, rx_level);
            else n_pass++;
        end
        wb_xfer(32'h4, 1'b0, 32'h0, 4'hF, a, e, r, lat);
        $display("STATUS read: ack=%0b data=%h", a, r);
        n_total++;
        if (a !== 1'b1 || r !== 32'h0005_0003)
            $display("FAIL status: got ack=%0b data=%h, expected 1/00050003", a, r);
        else n_pass++;
        while (rx_q.size() > 0) begin
            wb_xfer(32'h0, 1'b0, 32'h0, 4'hF, a, e, r, lat);
            exp = rx_q.pop_front();
            n_total++;
            if (a !== 1'b1 || r !== exp)
                $display("FAIL rx_drain: got ack=%0b data=%h, expected 1/%h", a, r, exp);
            else n_pass++;
        end
        test_tx_drain();
    endtask

    task automatic test_reset_mid();
        logic a, e; logic [31:0] r, exp; int lat;
        for (int i = 0; i < DEPTH / 2; i++) wb_xfer(32'h0, 1'b1, 32'hE000_0000 + 32'(i), 4'hF, a, e, r, lat);
        for (int i = 0; i < DEPTH / 2; i++) rx_push(32'hF000_0000 + 32'(i));
        n_total++;
        if (tx_level !== LW'(DEPTH / 2) || rx_level !== LW'(DEPTH / 2))
            $display("FAIL half_full: got tx=%0d rx=%0d, expected %0d/%0d", tx_level, rx_level, DEPTH / 2, DEPTH / 2);
        else n_pass++;
        adr = 32'h0; we = 1'b1; sel = 4'hF; cti = CTI_INCR; dat_w = 32'h7777_0000; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("mid-burst reset: ack=%0b tx=%0d rx=%0d tvalid=%0b", ack, tx_level, rx_level, m_tvalid);
        n_total++;
        if ({ack, err, m_tvalid, s_tready} !== 4'b0000 || tx_level !== '0 || rx_level !== '0 || dat_r !== 32'h0)
            $display("FAIL mid_reset: got ack/err/tvalid/tready=%b tx=%0d rx=%0d dat=%h, expected 0000/0/0/0",
                     {ack, err, m_tvalid, s_tready}, tx_level, rx_level, dat_r);
        else n_pass++;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        tx_q.delete(); rx_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_xfer(32'h0, 1'b1, 32'hC0DE_0001, 4'hF, a, e, r, lat);
        tx_q.push_back(32'hC0DE_0001);
        n_total++;
        if (a !== 1'b1 || tx_level !== LW'(1))
            $display("FAIL resume_write: got ack=%0b level=%0d, expected 1/1", a, tx_level);
        else n_pass++;
        test_tx_drain();
        rx_push(32'hC0DE_0002);
        wb_xfer(32'h0, 1'b0, 32'h0, 4'hF, a, e, r, lat);
        exp = rx_q.pop_front();
        $display("resume read: ack=%0b data=%h", a, r);
        n_total++;
        if (a !== 1'b1 || r !== exp) $display("FAIL resume_read: got ack=%0b data=%h, expected 1/%h", a, r, exp);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat_w = '0; sel = 4'hF; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        cti = CTI_CLASSIC; m_tready = 1'b0; s_tdata = '0; s_tvalid = 1'b0;
        test_reset();
        test_classic_write();
        test_classic_read();
        test_back_to_back();
        test_rx_stall();
        test_err_status();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
